id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. Sits directly upstream of the ALU.
- Latches decoded control and register-file operands, and resolves RAW hazards by forwarding from EX and MEM.
- Detects load-use hazards and asserts stall.
- Drives the ALU's operation, parameter1 and parameter2 from registers, so ALU inputs change only on clock edges.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register index width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  decoder presents an instruction
- in_ready  out  1  stage accepts it this cycle; equals not stall
- in_aluc  in  4  ALU operation code (package encoding)
- in_shift  in  1  parameter1 is the shift amount, not rs
- in_aluimm  in  1  parameter2 is the extended immediate, not rt
- in_sext  in  1  sign-extend immediate (else zero-extend)
- in_wreg, in_m2reg, in_wmem  in  1 each  register write, load, store
- in_uses_rs, in_uses_rt  in  1 each  instruction reads rs / rt
- in_rs, in_rt, in_rn  in  REG_AW each  source regs, destination reg
- in_sa  in  5  shift amount
- in_imm  in  16  immediate
- in_qa, in_qb  in  DATA_W  register-file read data (write-through for WB)
- flush  in  1  kill the instruction in ID (taken branch/jump)
- alu_result  in  DATA_W  combinational ALU output of the instruction now in EX
- mem_wreg, mem_m2reg  in  1  MEM-stage write enable, load flag
- mem_rn  in  REG_AW  MEM-stage destination
- mem_data  in  DATA_W  MEM-stage write-back value (ALU result or load data, already selected)
- stall  out  1  load-use hazard; holds IF/ID
- ex_valid  out  1  EX holds a real instruction
- operation  out  4  to ALU
- parameter1, parameter2  out  DATA_W  to ALU
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_wreg, ex_m2reg, ex_wmem  out  1  control carried to EX
- ex_rn  out  REG_AW  EX destination

Behaviour:
- Reset: every output register is 0, i.e. ex_valid=0 and operation=4'b0000 with zero parameters.
- stall is combinational: ex_valid & ex_m2reg & ex_rn!=0 & ((in_uses_rs & ex_rn==in_rs) | (in_uses_rt & ex_rn==in_rt)) & in_valid.
- Forwarding for source s (rs→fa, rt→fb), evaluated combinationally in ID, priority order:
  1. s==0: use the register-file value (r0 is never forwarded).
  2. ex_valid & ex_wreg & !ex_m2reg & ex_rn==s: use alu_result.
  3. mem_wreg & mem_rn==s: use mem_data.
  4. Otherwise: use in_qa / in_qb.
- Immediate extension: ext = in_sext ? {{16{imm[15]}},imm} : {16'b0,imm}.
- Operand selection: p1 = in_shift ? {27'b0,in_sa} : fa; p2 = in_aluimm ? ext : fb; store data = fb.
- Clock edge update:
  - Capture: in_valid & !stall & !flush → load all ex_* outputs, operation, parameters and store data; ex_valid=1.
  - Bubble: otherwise → ex_valid, ex_wreg, ex_m2reg, ex_wmem=0; operation=0, parameters=0, ex_rn=0.
- Simultaneous flush and stall: bubble; in_ready stays 0.
- Latency: exactly one cycle from ID to the ALU inputs.
- A load-use stall lasts exactly one cycle, because the load moves to MEM and the hazard clears.
- Reset asserted mid-stall: all outputs clear immediately; stall deasserts once ex_valid=0.

Optional Feature:
- Macro: ALU_FORWARD_EN.
- Defined: forwarding and load-use-only stall as above.
- Undefined: fa=in_qa and fb=in_qb. stall also asserts on any valid EX (ex_valid & ex_wreg) or MEM (mem_wreg) write to a nonzero register used by the ID instruction. Stall length is 1–2 cycles.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
  - Forward-select encoding: FWD_RF, FWD_EX, FWD_MEM.
  - REG_ZERO.
- One sub-module, operand_forward: a pure combinational priority select plus hazard compare, instantiated once per source.

Test Plan:
- EX/ALU forward: add r3,r1,r2 in EX with alu_result=0x0000_0010, next instruction sub r4,r3,r5 with in_qa=0xDEAD → parameter1=0x10, operation=0100.
- Priority: EX and MEM both write r7 (alu_result=5, mem_data=9); ID reads r7 → fa=5. Repeat with ex_rn=0 and mem_rn=0 → register-file value, no forwarding.
- Load-use: lw r8 in EX, then add r9,r8,r8 → stall=1 for one cycle, bubble ex_valid=0. Next cycle forward from MEM (mem_data=0x1234) → parameter1=parameter2=0x1234.
- Immediate and shift: andi imm=0x8001 sext=0 → parameter2=0x0000_8001. addi sext=1 → 0xFFFF_8001. sll sa=31 → parameter1=0x1F.
- Flush during stall, then async reset asserted mid-cycle → bubble captured; all outputs 0 without a clock edge.
- ALU_FORWARD_EN undefined: back-to-back dependent add → stall high 2 cycles, parameter1 taken from in_qa.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU opcodes,
// operand forward-select encoding and the hard-wired zero register.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM
    } fwd_sel_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// Per-source operand select and hazard compare for the ID/EX stage.
// ALU_FORWARD_EN selects bypassing; otherwise every pending write stalls.
module operand_forward
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic              uses_i,
    input  logic [DATA_W-1:0] rf_i,
    input  logic              ex_valid_i,
    input  logic              ex_wreg_i,
    input  logic              ex_m2reg_i,
    input  logic [REG_AW-1:0] ex_rn_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_rn_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              hazard_o
);

    logic is_zero;
    logic ex_hit;
    logic ld_hit;
    logic mem_hit;

    assign is_zero = (src_i == REG_AW'(REG_ZERO));
    assign ex_hit  = ex_valid_i & ex_wreg_i & (ex_rn_i == src_i);
    assign ld_hit  = ex_valid_i & ex_m2reg_i & (ex_rn_i == src_i);
    assign mem_hit = mem_wreg_i & (mem_rn_i == src_i);

`ifdef ALU_FORWARD_EN
    fwd_sel_e sel;

    // A load in EX has no data yet, so it is never an EX bypass source.
    always_comb begin
        sel = FWD_RF;
        if (is_zero) begin
            sel = FWD_RF;
        end else if (ex_hit & !ex_m2reg_i) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end
    end

    always_comb begin
        unique case (sel)
            FWD_EX:  data_o = alu_result_i;
            FWD_MEM: data_o = mem_data_i;
            default: data_o = rf_i;
        endcase
    end

    assign hazard_o = uses_i & !is_zero & ld_hit;
`else
    logic unused_bypass;

    assign unused_bypass = ^{alu_result_i, mem_data_i};
    assign data_o        = rf_i;
    assign hazard_o      = uses_i & !is_zero & (ex_hit | ld_hit | mem_hit);
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU from registers.
// Build with ALU_FORWARD_EN for EX/MEM bypassing and load-use-only stalls.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_aluc,
    input  logic              in_shift,
    input  logic              in_aluimm,
    input  logic              in_sext,
    input  logic              in_wreg,
    input  logic              in_m2reg,
    input  logic              in_wmem,
    input  logic              in_uses_rs,
    input  logic              in_uses_rt,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rn,
    input  logic [4:0]        in_sa,
    input  logic [15:0]       in_imm,
    input  logic [DATA_W-1:0] in_qa,
    input  logic [DATA_W-1:0] in_qb,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [REG_AW-1:0] mem_rn,
    input  logic [DATA_W-1:0] mem_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [3:0]        operation,
    output logic [DATA_W-1:0] parameter1,
    output logic [DATA_W-1:0] parameter2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_wreg,
    output logic              ex_m2reg,
    output logic              ex_wmem,
    output logic [REG_AW-1:0] ex_rn
);

    logic              valid_q;
    logic              wreg_q;
    logic              m2reg_q;
    logic              wmem_q;
    logic [REG_AW-1:0] rn_q;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] p1_q;
    logic [DATA_W-1:0] p2_q;
    logic [DATA_W-1:0] sd_q;

    logic [DATA_W-1:0] fa;
    logic [DATA_W-1:0] fb;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] p1_d;
    logic [DATA_W-1:0] p2_d;
    logic              haz_a;
    logic              haz_b;
    logic              capture;
    logic              unused_mem_m2reg;

    // Load data arrives already selected in mem_data.
    assign unused_mem_m2reg = mem_m2reg;

    operand_forward #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .src_i        (in_rs),
        .uses_i       (in_uses_rs),
        .rf_i         (in_qa),
        .ex_valid_i   (valid_q),
        .ex_wreg_i    (wreg_q),
        .ex_m2reg_i   (m2reg_q),
        .ex_rn_i      (rn_q),
        .alu_result_i (alu_result),
        .mem_wreg_i   (mem_wreg),
        .mem_rn_i     (mem_rn),
        .mem_data_i   (mem_data),
        .data_o       (fa),
        .hazard_o     (haz_a)
    );

    operand_forward #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .src_i        (in_rt),
        .uses_i       (in_uses_rt),
        .rf_i         (in_qb),
        .ex_valid_i   (valid_q),
        .ex_wreg_i    (wreg_q),
        .ex_m2reg_i   (m2reg_q),
        .ex_rn_i      (rn_q),
        .alu_result_i (alu_result),
        .mem_wreg_i   (mem_wreg),
        .mem_rn_i     (mem_rn),
        .mem_data_i   (mem_data),
        .data_o       (fb),
        .hazard_o     (haz_b)
    );

    assign stall    = in_valid & (haz_a | haz_b);
    assign in_ready = !stall;
    assign capture  = in_valid & !stall & !flush;

    assign ext  = {{(DATA_W-16){in_sext & in_imm[15]}}, in_imm};
    assign p1_d = in_shift ? {{(DATA_W-5){1'b0}}, in_sa} : fa;
    assign p2_d = in_aluimm ? ext : fb;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            rn_q    <= '0;
            op_q    <= ALU_ADD;
            p1_q    <= '0;
            p2_q    <= '0;
            sd_q    <= '0;
        end else if (capture) begin
            valid_q <= 1'b1;
            wreg_q  <= in_wreg;
            m2reg_q <= in_m2reg;
            wmem_q  <= in_wmem;
            rn_q    <= in_rn;
            op_q    <= in_aluc;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            sd_q    <= fb;
        end else begin
            valid_q <= 1'b0;
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            rn_q    <= '0;
            op_q    <= ALU_ADD;
            p1_q    <= '0;
            p2_q    <= '0;
            sd_q    <= '0;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_wreg       = wreg_q;
    assign ex_m2reg      = m2reg_q;
    assign ex_wmem       = wmem_q;
    assign ex_rn         = rn_q;
    assign operation     = op_q;
    assign parameter1    = p1_q;
    assign parameter2    = p2_q;
    assign ex_store_data = sd_q;

endmodule
